// File: rtl/systolic_array_controller.sv
// systolic_array_controller
// Job sequencer for a skewed systolic array. It loads ARRAY_HEIGHT weight rows,
// streams a programmed number of ifmap vectors, then drains the array with
// zeros until the last result has left the skew pipeline.
// Optional feature macro: SYSTOLIC_CTRL_WEIGHT_REUSE_EN. When it is defined,
// the reuse_weights input lets a job skip the weight load, provided a full
// weight load has completed since reset.
//
// state  | meaning
// IDLE   | waiting for start
// LOAD_W | accepting ARRAY_HEIGHT weight rows, one per weight_valid cycle
// STREAM | accepting n_reg ifmap vectors; ifmap_valid low stalls the array
// DRAIN  | feeding zeros for PIPE_LATENCY cycles to flush the results
// DONE   | one-cycle completion pulse, then back to IDLE

module systolic_array_controller #(
    parameter int ARRAY_HEIGHT = 4,
    parameter int ARRAY_WIDTH  = 4,
    parameter int PIPE_LATENCY = ARRAY_HEIGHT + ARRAY_WIDTH - 1,
    parameter int COUNT_WIDTH  = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [COUNT_WIDTH-1:0]  num_vectors,
`ifdef SYSTOLIC_CTRL_WEIGHT_REUSE_EN
    input  logic                    reuse_weights,
`endif
    output logic                    busy,
    output logic                    done,
    input  logic                    weight_valid,
    output logic                    weight_ready,
    input  logic                    ifmap_valid,
    output logic                    ifmap_ready,
    output logic                    en,
    output logic                    weight_en,
    output logic [ARRAY_HEIGHT-1:0] weight_wen,
    output logic                    ifmap_zero,
    output logic                    ofmap_valid
);

    localparam int ROW_W   = (ARRAY_HEIGHT > 1) ? $clog2(ARRAY_HEIGHT) : 1;
    localparam int DRAIN_W = (PIPE_LATENCY > 1) ? $clog2(PIPE_LATENCY) : 1;

    localparam logic [ROW_W-1:0]        LAST_ROW   = ROW_W'(ARRAY_HEIGHT - 1);
    localparam logic [ROW_W-1:0]        ROW_ONE    = ROW_W'(1);
    localparam logic [DRAIN_W-1:0]      DRAIN_LOAD = DRAIN_W'(PIPE_LATENCY - 1);
    localparam logic [DRAIN_W-1:0]      DRAIN_ONE  = DRAIN_W'(1);
    localparam logic [COUNT_WIDTH-1:0]  CNT_ONE    = COUNT_WIDTH'(1);
    localparam logic [ARRAY_HEIGHT-1:0] ROW0_SEL   = ARRAY_HEIGHT'(1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOAD_W = 3'd1,
        STREAM = 3'd2,
        DRAIN  = 3'd3,
        DONE   = 3'd4
    } state_t;

    state_t                   state;
    logic [COUNT_WIDTH-1:0]   n_reg;
    logic [COUNT_WIDTH-1:0]   vec_cnt;
    logic [ROW_W-1:0]         row_cnt;
    logic [DRAIN_W-1:0]       drain_cnt;
    logic [PIPE_LATENCY-1:0]  valid_pipe;

    // Registered phase flags, one per active phase, so that every output
    // below comes straight off a flop (gated only by the handshake inputs).
    logic                     load_mode;
    logic                     stream_mode;
    logic                     drain_mode;

`ifdef SYSTOLIC_CTRL_WEIGHT_REUSE_EN
    logic                     weights_loaded;
`endif

    // The last vector is accepted when vec_cnt reaches n_reg-1; n_reg is
    // never zero in STREAM, so the subtraction cannot underflow there.
    logic                     last_vector;
    assign last_vector = (vec_cnt == (n_reg - CNT_ONE));

    assign weight_en    = load_mode;
    assign weight_ready = load_mode;
    assign weight_wen   = (load_mode && weight_valid) ? (ROW0_SEL << row_cnt) : '0;
    assign ifmap_ready  = stream_mode;
    assign ifmap_zero   = drain_mode;
    assign en           = (stream_mode && ifmap_valid) || drain_mode;

    // Job sequencing FSM with registered phase flags, busy and done.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state          <= IDLE;
            n_reg          <= '0;
            vec_cnt        <= '0;
            row_cnt        <= '0;
            drain_cnt      <= '0;
            load_mode      <= 1'b0;
            stream_mode    <= 1'b0;
            drain_mode     <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
`ifdef SYSTOLIC_CTRL_WEIGHT_REUSE_EN
            weights_loaded <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        n_reg     <= num_vectors;
                        vec_cnt   <= '0;
                        row_cnt   <= '0;
                        drain_cnt <= '0;
                        busy      <= 1'b1;
`ifdef SYSTOLIC_CTRL_WEIGHT_REUSE_EN
                        if (reuse_weights && weights_loaded) begin
                            if (num_vectors == '0) begin
                                state <= DONE;
                                done  <= 1'b1;
                            end else begin
                                state       <= STREAM;
                                stream_mode <= 1'b1;
                            end
                        end else begin
                            state     <= LOAD_W;
                            load_mode <= 1'b1;
                        end
`else
                        state     <= LOAD_W;
                        load_mode <= 1'b1;
`endif
                    end
                end

                LOAD_W: begin
                    if (weight_valid) begin
                        if (row_cnt == LAST_ROW) begin
                            row_cnt   <= '0;
                            load_mode <= 1'b0;
`ifdef SYSTOLIC_CTRL_WEIGHT_REUSE_EN
                            weights_loaded <= 1'b1;
`endif
                            if (n_reg == '0) begin
                                state <= DONE;
                                done  <= 1'b1;
                            end else begin
                                state       <= STREAM;
                                stream_mode <= 1'b1;
                            end
                        end else begin
                            row_cnt <= row_cnt + ROW_ONE;
                        end
                    end
                end

                STREAM: begin
                    if (ifmap_valid) begin
                        vec_cnt <= vec_cnt + CNT_ONE;
                        if (last_vector) begin
                            state       <= DRAIN;
                            stream_mode <= 1'b0;
                            drain_mode  <= 1'b1;
                            drain_cnt   <= DRAIN_LOAD;
                        end
                    end
                end

                DRAIN: begin
                    if (drain_cnt == '0) begin
                        state      <= DONE;
                        drain_mode <= 1'b0;
                        done       <= 1'b1;
                    end else begin
                        drain_cnt <= drain_cnt - DRAIN_ONE;
                    end
                end

                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end

                default: begin
                    state       <= IDLE;
                    load_mode   <= 1'b0;
                    stream_mode <= 1'b0;
                    drain_mode  <= 1'b0;
                    busy        <= 1'b0;
                end
            endcase
        end
    end

    // Result-valid tracker: mirrors the array's skew, advancing only when the
    // array is enabled, and flags a result when a marker leaves the last stage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_pipe  <= '0;
            ofmap_valid <= 1'b0;
        end else begin
            ofmap_valid <= en && valid_pipe[PIPE_LATENCY-1];
            if (en) begin
                valid_pipe <= (valid_pipe << 1) | PIPE_LATENCY'(stream_mode);
            end
        end
    end

endmodule

// File: tb/tb_systolic_array_controller.sv
// Testbench for systolic_array_controller: schedule-based scoreboard of
// weight-row strobes, ofmap_valid cycle stamps and done timing.
module tb_systolic_array_controller;

    localparam int H  = 4;
    localparam int W  = 4;
    localparam int L  = H + W - 1;
    localparam int CW = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [CW-1:0] num_vectors;
    logic          weight_valid;
    logic          ifmap_valid;
`ifdef SYSTOLIC_CTRL_WEIGHT_REUSE_EN
    logic          reuse_weights;
`endif
    logic          busy;
    logic          done;
    logic          weight_ready;
    logic          ifmap_ready;
    logic          en;
    logic          weight_en;
    logic [H-1:0]  weight_wen;
    logic          ifmap_zero;
    logic          ofmap_valid;

    systolic_array_controller #(
        .ARRAY_HEIGHT(H),
        .ARRAY_WIDTH (W),
        .PIPE_LATENCY(L),
        .COUNT_WIDTH (CW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .num_vectors  (num_vectors),
`ifdef SYSTOLIC_CTRL_WEIGHT_REUSE_EN
        .reuse_weights(reuse_weights),
`endif
        .busy         (busy),
        .done         (done),
        .weight_valid (weight_valid),
        .weight_ready (weight_ready),
        .ifmap_valid  (ifmap_valid),
        .ifmap_ready  (ifmap_ready),
        .en           (en),
        .weight_en    (weight_en),
        .weight_wen   (weight_wen),
        .ifmap_zero   (ifmap_zero),
        .ofmap_valid  (ofmap_valid)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Observed events, stamped with the index of the most recent rising edge.
    int           obs_ofm[$];
    int           obs_done[$];
    int           obs_ready[$];
    logic [H-1:0] obs_wen[$];
    // Expected events, pushed by the stimulus driver.
    int           exp_ofm[$];
    logic [H-1:0] exp_wen[$];

    // Running event counters (written only by the monitor).
    int   wen_cyc    = 0;
    int   en_in_load = 0;
    int   wen_bad    = 0;
    int   en_cyc     = 0;
    int   zero_cyc   = 0;
    int   zero_en    = 0;
    int   stall_bad  = 0;
    logic ready_d    = 1'b0;
    // Baselines captured at job start.
    int   b_wen, b_load, b_bad, b_en, b_zero, b_zen, b_stall;

    bit in_stall      = 1'b0;
    bit in_stall_late = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        ready_d <= ifmap_ready;
        if (ifmap_ready && !ready_d) obs_ready.push_back(cyc);
        if (ofmap_valid) obs_ofm.push_back(cyc);
        if (done) obs_done.push_back(cyc);
        if (weight_wen != '0) begin
            obs_wen.push_back(weight_wen);
            if (!weight_valid) wen_bad <= wen_bad + 1;
        end
        if (weight_en) wen_cyc <= wen_cyc + 1;
        if (weight_en && (en || ifmap_ready)) en_in_load <= en_in_load + 1;
        if (en) en_cyc <= en_cyc + 1;
        if (ifmap_zero) zero_cyc <= zero_cyc + 1;
        if (ifmap_zero && en && !ifmap_ready) zero_en <= zero_en + 1;
        if ((in_stall && en) || (in_stall_late && ofmap_valid)) stall_bad <= stall_bad + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives one job and pushes the expected strobes. Returns in the DONE
    // cycle, or in drain cycle stop_drain when stop_drain > 0.
    task automatic drive_job(input int n, input bit wtoggle, input bit skip_load,
                             input int stall_at, input int stall_len, input int stop_drain,
                             output int start_edge, output int exp_done);
        int en_edges[$];
        int rows, ph, vi, srem;
        logic [H-1:0] sel;
        obs_ofm.delete(); obs_done.delete(); obs_ready.delete(); obs_wen.delete();
        exp_ofm.delete(); exp_wen.delete();
        b_wen = wen_cyc; b_load = en_in_load; b_bad = wen_bad; b_en = en_cyc;
        b_zero = zero_cyc; b_zen = zero_en; b_stall = stall_bad;
        start        = 1'b1;
        num_vectors  = n[CW-1:0];
        weight_valid = 1'b0;
        ifmap_valid  = 1'b0;
        start_edge   = cyc + 1;
        tick();
        start = 1'b0;
        if (!skip_load) begin
            rows = 0;
            ph   = 0;
            while (rows < H) begin
                weight_valid = wtoggle ? (ph % 2 == 0) : 1'b1;
                ifmap_valid  = 1'b1;
                if (weight_valid) begin
                    sel = H'(1);
                    sel = sel << rows;
                    exp_wen.push_back(sel);
                    rows++;
                end
                ph++;
                tick();
            end
            weight_valid = 1'b0;
            ifmap_valid  = 1'b0;
        end
        if (n == 0) begin
            exp_done = cyc;
        end else begin
            vi   = 0;
            srem = stall_len;
            while (vi < n) begin
                if (vi == stall_at && srem > 0) begin
                    ifmap_valid   = 1'b0;
                    in_stall      = 1'b1;
                    in_stall_late = (srem < stall_len);
                    srem--;
                end else begin
                    ifmap_valid   = 1'b1;
                    in_stall      = 1'b0;
                    in_stall_late = 1'b0;
                    en_edges.push_back(cyc + 1);
                    vi++;
                end
                tick();
            end
            ifmap_valid   = 1'b0;
            in_stall      = 1'b0;
            in_stall_late = 1'b0;
            for (int k = 1; k <= L; k++) en_edges.push_back(cyc + k);
            exp_done = cyc + L;
            for (int i = 0; i < n; i++) exp_ofm.push_back(en_edges[i + L]);
        end
        if (stop_drain > 0) repeat (stop_drain - 1) tick();
        else while (cyc < exp_done) tick();
    endtask

    task automatic test_reset();
        logic [H+7:0] outs;
        rst = 1'b1; start = 1'b0; num_vectors = '0; weight_valid = 1'b0; ifmap_valid = 1'b0;
`ifdef SYSTOLIC_CTRL_WEIGHT_REUSE_EN
        reuse_weights = 1'b0;
`endif
        repeat (2) tick();
        outs = {busy, done, weight_ready, ifmap_ready, en, weight_en, ifmap_zero, ofmap_valid, weight_wen};
        n_checks++;
        if (outs !== '0) begin n_fail++; $display("FAIL reset_outputs: got %b expected all zero", outs); end
        rst = 1'b0;
        tick();
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_idle_busy: got %b expected 0", busy); end
    endtask

    task automatic test_basic();
        int s, d, e, o;
        logic [H-1:0] ew, ow;
        drive_job(3, 1'b0, 1'b0, -1, 0, 0, s, d);
        start = 1'b1;
        num_vectors = 16'd5;
        tick();
        start = 1'b0;
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL basic_start_in_done: busy %b expected 0", busy); end
        repeat (2) tick();
        n_checks++;
        if (obs_wen.size() != exp_wen.size()) begin n_fail++; $display("FAIL basic_wen_count: got %0d expected %0d", obs_wen.size(), exp_wen.size()); end
        while (exp_wen.size() > 0 && obs_wen.size() > 0) begin
            ew = exp_wen.pop_front(); ow = obs_wen.pop_front();
            n_checks++;
            if (ow !== ew) begin n_fail++; $display("FAIL basic_wen_value: got %b expected %b", ow, ew); end
        end
        n_checks++;
        if (obs_ofm.size() != exp_ofm.size()) begin n_fail++; $display("FAIL basic_ofm_count: got %0d expected %0d", obs_ofm.size(), exp_ofm.size()); end
        while (exp_ofm.size() > 0 && obs_ofm.size() > 0) begin
            e = exp_ofm.pop_front(); o = obs_ofm.pop_front();
            n_checks++;
            if (o !== e) begin n_fail++; $display("FAIL basic_ofm_cycle: got %0d expected %0d", o, e); end
        end
        n_checks++;
        if (obs_done.size() != 1 || obs_done[0] != d) begin n_fail++; $display("FAIL basic_done: got %0d pulses first %0d expected 1 at %0d", obs_done.size(), (obs_done.size() > 0) ? obs_done[0] : -1, d); end
        n_checks++;
        if (wen_cyc - b_wen != H) begin n_fail++; $display("FAIL basic_load_len: got %0d expected %0d", wen_cyc - b_wen, H); end
        n_checks++;
        if (en_in_load - b_load != 0) begin n_fail++; $display("FAIL basic_ifmap_in_load: got %0d expected 0", en_in_load - b_load); end
        n_checks++;
        if (en_cyc - b_en != 3 + L) begin n_fail++; $display("FAIL basic_en_cycles: got %0d expected %0d", en_cyc - b_en, 3 + L); end
        n_checks++;
        if (zero_en - b_zen != L || zero_cyc - b_zero != L) begin n_fail++; $display("FAIL basic_drain: got zero %0d zero_en %0d expected %0d", zero_cyc - b_zero, zero_en - b_zen, L); end
        n_checks++;
        if (obs_ready.size() < 1 || obs_ready[0] != s + H) begin n_fail++; $display("FAIL basic_stream_entry: got %0d expected %0d", (obs_ready.size() > 0) ? obs_ready[0] : -1, s + H); end
    endtask

    task automatic test_weight_backpressure();
        int s, d;
        logic [H-1:0] ew, ow;
        drive_job(1, 1'b1, 1'b0, -1, 0, 0, s, d);
        repeat (2) tick();
        n_checks++;
        if (wen_cyc - b_wen != 2 * H - 1) begin n_fail++; $display("FAIL bp_load_len: got %0d expected %0d", wen_cyc - b_wen, 2 * H - 1); end
        n_checks++;
        if (wen_bad - b_bad != 0) begin n_fail++; $display("FAIL bp_wen_without_valid: got %0d expected 0", wen_bad - b_bad); end
        n_checks++;
        if (obs_wen.size() != exp_wen.size()) begin n_fail++; $display("FAIL bp_wen_count: got %0d expected %0d", obs_wen.size(), exp_wen.size()); end
        while (exp_wen.size() > 0 && obs_wen.size() > 0) begin
            ew = exp_wen.pop_front(); ow = obs_wen.pop_front();
            n_checks++;
            if (ow !== ew) begin n_fail++; $display("FAIL bp_wen_value: got %b expected %b", ow, ew); end
        end
        n_checks++;
        if (obs_ofm.size() != 1 || obs_ofm[0] != exp_ofm[0]) begin n_fail++; $display("FAIL bp_ofm: got %0d pulses expected 1 at %0d", obs_ofm.size(), exp_ofm[0]); end
        n_checks++;
        if (obs_done.size() != 1 || obs_done[0] != d) begin n_fail++; $display("FAIL bp_done: got %0d pulses expected 1 at %0d", obs_done.size(), d); end
    endtask

    task automatic test_ifmap_stall();
        int s, d, e, o;
        drive_job(4, 1'b0, 1'b0, 2, 5, 0, s, d);
        repeat (2) tick();
        n_checks++;
        if (stall_bad - b_stall != 0) begin n_fail++; $display("FAIL stall_activity: got %0d cycles with en/ofmap_valid expected 0", stall_bad - b_stall); end
        n_checks++;
        if (en_cyc - b_en != 4 + L) begin n_fail++; $display("FAIL stall_en_cycles: got %0d expected %0d", en_cyc - b_en, 4 + L); end
        n_checks++;
        if (obs_ofm.size() != exp_ofm.size()) begin n_fail++; $display("FAIL stall_ofm_count: got %0d expected %0d", obs_ofm.size(), exp_ofm.size()); end
        while (exp_ofm.size() > 0 && obs_ofm.size() > 0) begin
            e = exp_ofm.pop_front(); o = obs_ofm.pop_front();
            n_checks++;
            if (o !== e) begin n_fail++; $display("FAIL stall_ofm_cycle: got %0d expected %0d", o, e); end
        end
        n_checks++;
        if (obs_done.size() != 1 || obs_done[0] != d) begin n_fail++; $display("FAIL stall_done: got %0d pulses expected 1 at %0d", obs_done.size(), d); end
    endtask

    task automatic test_zero_vectors();
        int s, d;
        drive_job(0, 1'b0, 1'b0, -1, 0, 0, s, d);
        repeat (2) tick();
        n_checks++;
        if (obs_wen.size() != H) begin n_fail++; $display("FAIL zero_rows: got %0d expected %0d", obs_wen.size(), H); end
        n_checks++;
        if (en_cyc - b_en != 0) begin n_fail++; $display("FAIL zero_en: got %0d expected 0", en_cyc - b_en); end
        n_checks++;
        if (obs_ofm.size() != 0) begin n_fail++; $display("FAIL zero_ofm: got %0d expected 0", obs_ofm.size()); end
        n_checks++;
        if (obs_done.size() != 1 || obs_done[0] != s + H) begin n_fail++; $display("FAIL zero_done: got %0d pulses expected 1 at %0d", obs_done.size(), s + H); end
    endtask

    task automatic test_reset_mid_drain();
        int s, d, e, o;
        logic [H+7:0] outs;
        drive_job(3, 1'b0, 1'b0, -1, 0, 3, s, d);
        n_checks++;
        if (busy !== 1'b1 || ifmap_zero !== 1'b1 || en !== 1'b1) begin n_fail++; $display("FAIL rst_pre_drain: got busy %b zero %b en %b expected 1 1 1", busy, ifmap_zero, en); end
        #1 rst = 1'b1;
        #1;
        outs = {busy, done, weight_ready, ifmap_ready, en, weight_en, ifmap_zero, ofmap_valid, weight_wen};
        n_checks++;
        if (outs !== '0) begin n_fail++; $display("FAIL rst_async_outputs: got %b expected all zero", outs); end
        tick();
        rst = 1'b0;
        tick();
        drive_job(3, 1'b0, 1'b0, -1, 0, 0, s, d);
        repeat (2) tick();
        n_checks++;
        if (wen_cyc - b_wen != H) begin n_fail++; $display("FAIL rst_rerun_load: got %0d expected %0d", wen_cyc - b_wen, H); end
        n_checks++;
        if (obs_ofm.size() != exp_ofm.size()) begin n_fail++; $display("FAIL rst_rerun_ofm_count: got %0d expected %0d", obs_ofm.size(), exp_ofm.size()); end
        while (exp_ofm.size() > 0 && obs_ofm.size() > 0) begin
            e = exp_ofm.pop_front(); o = obs_ofm.pop_front();
            n_checks++;
            if (o !== e) begin n_fail++; $display("FAIL rst_rerun_ofm_cycle: got %0d expected %0d", o, e); end
        end
        n_checks++;
        if (obs_done.size() != 1 || obs_done[0] != d) begin n_fail++; $display("FAIL rst_rerun_done: got %0d pulses expected 1 at %0d", obs_done.size(), d); end
    endtask

`ifdef SYSTOLIC_CTRL_WEIGHT_REUSE_EN
    task automatic test_weight_reuse();
        int s, d, e, o;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        reuse_weights = 1'b1;
        drive_job(2, 1'b0, 1'b0, -1, 0, 0, s, d);
        reuse_weights = 1'b0;
        repeat (2) tick();
        n_checks++;
        if (wen_cyc - b_wen != H) begin n_fail++; $display("FAIL reuse_before_load: got %0d load cycles expected %0d", wen_cyc - b_wen, H); end
        reuse_weights = 1'b1;
        drive_job(2, 1'b0, 1'b1, -1, 0, 0, s, d);
        reuse_weights = 1'b0;
        repeat (2) tick();
        n_checks++;
        if (wen_cyc - b_wen != 0) begin n_fail++; $display("FAIL reuse_weight_en: got %0d cycles expected 0", wen_cyc - b_wen); end
        n_checks++;
        if (obs_ready.size() < 1 || obs_ready[0] != s) begin n_fail++; $display("FAIL reuse_stream_entry: got %0d expected %0d", (obs_ready.size() > 0) ? obs_ready[0] : -1, s); end
        n_checks++;
        if (obs_ofm.size() != exp_ofm.size()) begin n_fail++; $display("FAIL reuse_ofm_count: got %0d expected %0d", obs_ofm.size(), exp_ofm.size()); end
        while (exp_ofm.size() > 0 && obs_ofm.size() > 0) begin
            e = exp_ofm.pop_front(); o = obs_ofm.pop_front();
            n_checks++;
            if (o !== e) begin n_fail++; $display("FAIL reuse_ofm_cycle: got %0d expected %0d", o, e); end
        end
        n_checks++;
        if (obs_done.size() != 1 || obs_done[0] != d) begin n_fail++; $display("FAIL reuse_done: got %0d pulses expected 1 at %0d", obs_done.size(), d); end
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_weight_backpressure();
        test_ifmap_stall();
        test_zero_vectors();
        test_reset_mid_drain();
`ifdef SYSTOLIC_CTRL_WEIGHT_REUSE_EN
        test_weight_reuse();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/systolic_array_controller.md
Name: systolic_array_controller

Overview:
- Sequencer for the skewed systolic array: loads one weight row per handshake, streams a programmed number of ifmap vectors, then drains the pipeline.
- Drives the array's en, weight_en and weight_wen, plus a zero-select for the ifmap mux.
- Produces an ofmap_valid strobe aligned to ofmap_out.
- Sits between the layer-level scheduler (start/done) and the array datapath.

Parameters:
- ARRAY_HEIGHT, 4, rows in the array; number of weight rows loaded per job.
- ARRAY_WIDTH, 4, columns in the array; used only for the PIPE_LATENCY default.
- PIPE_LATENCY, ARRAY_HEIGHT+ARRAY_WIDTH-1, en-high clock edges from accepting an ifmap vector to its result on ofmap_out.
- COUNT_WIDTH, 16, width of the vector count.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous active-high reset.
- start  input  1  begin a job; sampled only in IDLE.
- num_vectors  input  COUNT_WIDTH  ifmap vectors in the job; captured on start.
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle pulse when the job completes.
- weight_valid  input  1  weight row present on weight_in.
- weight_ready  output  1  controller accepts a weight row.
- ifmap_valid  input  1  ifmap vector present.
- ifmap_ready  output  1  controller accepts an ifmap vector.
- en  output  1  array/skew-register enable.
- weight_en  output  1  array weight-load mode.
- weight_wen  output  ARRAY_HEIGHT  one-hot row write enable.
- ifmap_zero  output  1  selects zeros into ifmap_in during drain.
- ofmap_valid  output  1  ofmap_out holds one vector's result.

Behaviour:
- Reset (async, any state): state=IDLE, all counters 0, valid pipe 0. All outputs 0.
- States: IDLE, LOAD_W, STREAM, DRAIN, DONE.
- IDLE:
  - start=1 captures num_vectors into n_reg, clears counters, moves to LOAD_W.
  - start in any other state is ignored.
- LOAD_W:
  - weight_en=1, weight_ready=1.
  - A row is accepted on a cycle with weight_valid=1. That cycle: weight_wen[row_cnt]=1 (only bit set), then row_cnt++.
  - weight_wen=0 whenever weight_valid=0.
  - en=0 throughout.
  - After row ARRAY_HEIGHT-1 is accepted: go to STREAM, or to DONE if n_reg==0.
- STREAM:
  - ifmap_ready=1; en = ifmap_valid (combinational).
  - Each accepted vector: vec_cnt++, and a 1 is shifted into valid_pipe.
  - ifmap_valid=0 stalls: en=0, array and valid_pipe frozen.
  - On accepting vector n_reg-1: go to DRAIN.
- DRAIN:
  - en=1, ifmap_zero=1, ifmap_ready=0; 0 is shifted into valid_pipe.
  - Lasts exactly PIPE_LATENCY cycles (drain_cnt), then DONE.
- DONE: done=1 for one cycle, then IDLE.
- valid_pipe:
  - PIPE_LATENCY bits, shifts only on en-high edges.
  - ofmap_valid is registered: high in the cycle after an en-high edge moves a 1 out of the last stage. It is low in every other cycle, including stall cycles.
  - Exactly n_reg ofmap_valid pulses per job, in input order. The last pulse occurs in the DONE cycle.
- Widths: vec_cnt is COUNT_WIDTH bits, compared with ==, no wrap. num_vectors=2^COUNT_WIDTH-1 is legal.
- Simultaneous events:
  - In the final LOAD_W row cycle, ifmap_valid is ignored (ifmap_ready=0).
  - start asserted in the DONE cycle is ignored; it must be re-asserted in IDLE.
- Reset mid-job: state and outputs return to reset values immediately. The array contents are the datapath's responsibility.

Optional Feature:
- Macro: SYSTOLIC_CTRL_WEIGHT_REUSE_EN.
- When defined:
  - Adds input reuse_weights (1 bit), sampled with start.
  - reuse_weights=1 skips LOAD_W and goes IDLE->STREAM, or IDLE->DONE if num_vectors==0.
  - It is honoured only if a complete LOAD_W has finished since reset. Otherwise LOAD_W runs as normal.
- When undefined: port absent; every job runs LOAD_W.

Test Plan:
- Basic job: reset, start with num_vectors=3, weight_valid held high.
  - weight_wen = 0001, 0010, 0100, 1000 on four consecutive cycles.
  - 3 STREAM cycles, then 7 DRAIN cycles with en=1.
  - Exactly 3 ofmap_valid pulses, the first 7 en-edges after the first vector is accepted; done pulse follows.
- Weight backpressure: weight_valid toggles 1,0,1,0,... -> weight_wen bits appear only on valid cycles; LOAD_W lasts 7 cycles.
- Ifmap stall: num_vectors=4 with ifmap_valid low for 5 cycles after vector 2 -> en=0 and no ofmap_valid during the stall; still exactly 4 pulses, in order.
- Zero vectors: num_vectors=0 -> 4 weight rows loaded, en never high, done 1 cycle after the last row, 0 ofmap_valid.
- Reset mid-DRAIN: assert rst in drain cycle 3 -> busy, en, ofmap_valid go 0 asynchronously; next start runs a full job normally.
- Macro enabled: after a first job, start with reuse_weights=1, num_vectors=2 -> weight_en never high; STREAM is entered the cycle after start.
